// File: rtl/posit_pkg.sv
// Shared width helpers, posit constants and the unpacked-operand bus type for the posit packer.
package posit_pkg;

    function automatic int fw_of(input int n, input int es);
        return n - es - 3;
    endfunction

    function automatic int sw_of(input int n, input int es);
        return $clog2((n - 1) << es) + 2;
    endfunction

    function automatic logic [63:0] maxpos_of(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] minpos_of(input int n);
        return (n > 1) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] nar_of(input int n);
        return 64'd1 << (n - 1);
    endfunction

    // Shaped for the default 32-bit, es=2 configuration (scale 9 bits, fraction 29 bits).
    typedef struct packed {
        logic              sign;
        logic signed [8:0] scale;
        logic [28:0]       frac;
        logic              sticky;
        logic              zero;
        logic              nar;
    } unpacked_posit_t;

endpackage

// File: rtl/posit_regime_gen.sv
// Regime run generator: left-aligned regime bits for a clamped k, plus the run length including the terminator.
module posit_regime_gen #(
    parameter int N  = 32,
    parameter int SW = 9,
    localparam int RLW = $clog2(N)
) (
    input  logic signed [SW-1:0] k,
    output logic [N-2:0]         regime,
    output logic [RLW-1:0]       rl
);

    int kv;

    // A positive run that fills the word drops its terminating 0, hence the cap at N-1.
    always_comb begin
        kv = int'(k);
        if (kv >= 0) begin
            regime = ~({(N-1){1'b1}} >> (kv + 1));
            rl     = (kv + 2 > N - 1) ? RLW'(N - 1) : RLW'(kv + 2);
        end else begin
            regime = {1'b1, {(N-2){1'b0}}} >> (-kv);
            rl     = RLW'(1 - kv);
        end
    end

endmodule

// File: rtl/posit_encode.sv
// Posit packer: unpacked sign/scale/fraction to an N-bit posit with RNE rounding and saturation.
// Three register stages (decode, body build, round/pack) that advance and stall as one.
module posit_encode
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 2,
    localparam int FW = fw_of(N, ES),
    localparam int SW = sw_of(N, ES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [SW-1:0] in_scale,
    input  logic [FW+1:0]        in_frac,
    input  logic                 in_sticky,
    input  logic                 in_zero,
    input  logic                 in_nar,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_posit
);

    localparam int EW   = (ES > 0) ? ES : 1;
    localparam int RLW  = $clog2(N);
    localparam int TW   = ES + FW + 3;
    localparam int BW   = N + FW + ES + 3;
    localparam int KMAX = N - 2;

    localparam logic signed [SW-1:0] K_HI    = SW'(KMAX);
    localparam logic signed [SW-1:0] K_LO    = SW'(-KMAX);
    localparam logic [N-2:0]         MAG_MAX = (N-1)'(maxpos_of(N));
    localparam logic [N-2:0]         MAG_MIN = (N-1)'(minpos_of(N));
    localparam logic [N-1:0]         NAR     = N'(nar_of(N));

    logic advance;
    logic s1_valid, s2_valid, s3_valid;

    // S1: split scale into regime index and exponent, clamp the index
    logic signed [SW-1:0] k_raw, k_clamp;
    logic                 sat_hi, sat_lo;

    always_comb begin
        k_raw   = in_scale >>> ES;
        sat_hi  = k_raw > K_HI;
        sat_lo  = k_raw < K_LO;
        k_clamp = sat_hi ? K_HI : (sat_lo ? K_LO : k_raw);
    end

    logic                 s1_sign, s1_zero, s1_nar, s1_sat_hi, s1_sat_lo, s1_sticky;
    logic signed [SW-1:0] s1_k;
    logic [EW-1:0]        s1_e;
    logic [FW+1:0]        s1_frac;

    // S2: assemble the body and split it into kept/guard/sticky
    logic [N-2:0]   regime;
    logic [RLW-1:0] rl;
    logic [TW-1:0]  tail;
    logic [BW-1:0]  body;

    posit_regime_gen #(.N(N), .SW(SW)) u_regime (
        .k      (s1_k),
        .regime (regime),
        .rl     (rl)
    );

    generate
        if (ES > 0) begin : g_tail_e
            assign tail = {s1_e, s1_frac, s1_sticky};
        end else begin : g_tail_no_e
            assign tail = {s1_frac, s1_sticky};
        end
    endgenerate

    assign body = {regime, {(BW-N+1){1'b0}}} | ({tail, {N{1'b0}}} >> rl);

    logic         s2_sign, s2_zero, s2_nar, s2_sat_hi, s2_sat_lo, s2_guard, s2_sticky;
    logic [N-2:0] s2_kept;

    // S3: round to nearest even, keep the magnitude inside [minpos, maxpos], apply sign
    logic         inc;
    logic [N-1:0] mag_sum;
    logic [N-2:0] mag;
    logic [N-1:0] result;

    always_comb begin
        inc     = s2_guard & (s2_kept[0] | s2_sticky);
        mag_sum = {1'b0, s2_kept} + {{(N-1){1'b0}}, inc};
        if (mag_sum[N-1])
            mag = MAG_MAX;
        else if (mag_sum[N-2:0] == '0)
            mag = MAG_MIN;
        else
            mag = mag_sum[N-2:0];
        if (s2_sat_hi)
            mag = MAG_MAX;
        else if (s2_sat_lo)
            mag = MAG_MIN;
        result = s2_sign ? -{1'b0, mag} : {1'b0, mag};
        if (s2_nar)
            result = NAR;
        else if (s2_zero)
            result = '0;
    end

    logic [N-1:0] s3_posit;

    assign advance   = !s3_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_valid;
    assign out_posit = s3_posit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s3_posit <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s3_posit <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign   <= in_sign;
            s1_zero   <= in_zero;
            s1_nar    <= in_nar;
            s1_sat_hi <= sat_hi;
            s1_sat_lo <= sat_lo;
            s1_k      <= k_clamp;
            s1_e      <= in_scale[EW-1:0];
            s1_frac   <= in_frac;
            s1_sticky <= in_sticky;

            s2_sign   <= s1_sign;
            s2_zero   <= s1_zero;
            s2_nar    <= s1_nar;
            s2_sat_hi <= s1_sat_hi;
            s2_sat_lo <= s1_sat_lo;
            s2_kept   <= body[BW-1 -: N-1];
            s2_guard  <= body[BW-N];
            s2_sticky <= |body[BW-N-1:0];
        end
    end

endmodule

// File: tb/tb_posit_encode.sv
// Directed bench for posit_encode at N=8, ES=2 with hand-computed posit patterns.
module tb_posit_encode;

    localparam int N  = 8;
    localparam int ES = 2;
    localparam int SW = 7;
    localparam int FW = 3;

    typedef struct {
        logic        sgn;
        int          sc;
        logic [4:0]  fr;
        logic        st;
        logic        zr;
        logic        nr;
        logic [7:0]  ex;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic signed [SW-1:0] in_scale;
    logic [FW+1:0]        in_frac;
    logic                 in_sticky;
    logic                 in_zero;
    logic                 in_nar;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out_posit;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    posit_encode #(.N(N), .ES(ES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_scale  (in_scale),
        .in_frac   (in_frac),
        .in_sticky (in_sticky),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    task automatic drive(input vec_t v);
        in_sign   = v.sgn;
        in_scale  = SW'(v.sc);
        in_frac   = v.fr;
        in_sticky = v.st;
        in_zero   = v.zr;
        in_nar    = v.nr;
    endtask

    // Sends one beat into an idle pipe and returns the first output seen within a bounded wait.
    task automatic send_get(input vec_t v, output logic [7:0] got, output bit ok);
        @(negedge clk);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        got = out_posit;
    endtask

    task automatic test_reset;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_posit !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_posit: got %h expected 00", out_posit);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic;
        vec_t t[6];
        logic [7:0] got;
        bit ok;
        t = '{'{1'b0,  0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h40},
              '{1'b1,  0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'hC0},
              '{1'b0,  5, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h64},
              '{1'b0, -1, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h38},
              '{1'b0,  2, 5'b10100, 1'b0, 1'b0, 1'b0, 8'h55},
              '{1'b1,  4, 5'b01000, 1'b0, 1'b0, 1'b0, 8'h9F}};
        for (int i = 0; i < 6; i++) begin
            send_get(t[i], got, ok);
            checks++;
            if (!ok || got !== t[i].ex) begin
                errors++;
                $display("FAIL basic[%0d]: got %h (valid=%0d) expected %h", i, got, ok, t[i].ex);
            end
        end
    endtask

    task automatic test_rne;
        vec_t t[6];
        logic [7:0] got;
        bit ok;
        t = '{'{1'b0,  0, 5'b00010, 1'b0, 1'b0, 1'b0, 8'h40},
              '{1'b0,  0, 5'b00010, 1'b1, 1'b0, 1'b0, 8'h41},
              '{1'b0,  0, 5'b00110, 1'b0, 1'b0, 1'b0, 8'h42},
              '{1'b0, -9, 5'b11000, 1'b0, 1'b0, 1'b0, 8'h10},
              '{1'b0, 23, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h7F},
              '{1'b0, 27, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h7F}};
        for (int i = 0; i < 6; i++) begin
            send_get(t[i], got, ok);
            checks++;
            if (!ok || got !== t[i].ex) begin
                errors++;
                $display("FAIL rne[%0d]: got %h (valid=%0d) expected %h", i, got, ok, t[i].ex);
            end
        end
    endtask

    task automatic test_saturation;
        vec_t t[7];
        logic [7:0] got;
        bit ok;
        t = '{'{1'b0,  63, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h7F},
              '{1'b0, -64, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h01},
              '{1'b1, -64, 5'b00000, 1'b0, 1'b0, 1'b0, 8'hFF},
              '{1'b1,  63, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h81},
              '{1'b0,  24, 5'b11111, 1'b0, 1'b0, 1'b0, 8'h7F},
              '{1'b0, -24, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h01},
              '{1'b0, -25, 5'b11111, 1'b1, 1'b0, 1'b0, 8'h01}};
        for (int i = 0; i < 7; i++) begin
            send_get(t[i], got, ok);
            checks++;
            if (!ok || got !== t[i].ex) begin
                errors++;
                $display("FAIL saturation[%0d]: got %h (valid=%0d) expected %h", i, got, ok, t[i].ex);
            end
        end
    endtask

    task automatic test_specials;
        vec_t t[4];
        logic [7:0] got;
        bit ok;
        t = '{'{1'b0,  5, 5'b00000, 1'b0, 1'b1, 1'b0, 8'h00},
              '{1'b0,  5, 5'b00000, 1'b0, 1'b0, 1'b1, 8'h80},
              '{1'b1,  5, 5'b00000, 1'b0, 1'b1, 1'b1, 8'h80},
              '{1'b1, -3, 5'b11111, 1'b1, 1'b1, 1'b0, 8'h00}};
        for (int i = 0; i < 4; i++) begin
            send_get(t[i], got, ok);
            checks++;
            if (!ok || got !== t[i].ex) begin
                errors++;
                $display("FAIL specials[%0d]: got %h (valid=%0d) expected %h", i, got, ok, t[i].ex);
            end
        end
    endtask

    task automatic test_backpressure;
        vec_t t[10];
        logic [7:0] held;
        bit holding;
        int tx, rx, cyc;
        t = '{'{1'b0,   0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h40},
              '{1'b1,   0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'hC0},
              '{1'b0,   5, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h64},
              '{1'b0,  -1, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h38},
              '{1'b0,   2, 5'b10100, 1'b0, 1'b0, 1'b0, 8'h55},
              '{1'b1,   4, 5'b01000, 1'b0, 1'b0, 1'b0, 8'h9F},
              '{1'b0,   0, 5'b00010, 1'b1, 1'b0, 1'b0, 8'h41},
              '{1'b0,  -9, 5'b11000, 1'b0, 1'b0, 1'b0, 8'h10},
              '{1'b0,   0, 5'b00110, 1'b0, 1'b0, 1'b0, 8'h42},
              '{1'b1, -64, 5'b00000, 1'b0, 1'b0, 1'b0, 8'hFF}};
        tx = 0;
        rx = 0;
        cyc = 0;
        holding = 1'b0;
        held = 8'h00;
        while (rx < 10 && cyc < 300) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 1) == 1);
            if (tx < 10) begin
                drive(t[tx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (holding) begin
                checks++;
                if (out_valid !== 1'b1 || out_posit !== held) begin
                    errors++;
                    $display("FAIL bp_hold: got valid=%b posit=%h expected valid=1 posit=%h", out_valid, out_posit, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_posit !== t[rx].ex) begin
                    errors++;
                    $display("FAIL bp_data[%0d]: got %h expected %h", rx, out_posit, t[rx].ex);
                end
                rx++;
                holding = 1'b0;
            end else if (out_valid) begin
                holding = 1'b1;
                held = out_posit;
            end else begin
                holding = 1'b0;
            end
            if (in_valid && in_ready) tx++;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rx != 10) begin
            errors++;
            $display("FAIL bp_count: got %0d beats expected 10", rx);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_extra: got out_valid=%b after drain expected 0", out_valid);
        end
    endtask

    task automatic test_reset_inflight;
        vec_t a, b;
        a = '{1'b0, 2, 5'b10100, 1'b0, 1'b0, 1'b0, 8'h55};
        b = '{1'b0, 5, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h64};
        @(negedge clk);
        out_ready = 1'b0;
        drive(a);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_fill: got out_valid=%b expected 1", out_valid);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_posit !== 8'h00) begin
            errors++;
            $display("FAIL rst_flush_posit: got %h expected 00", out_posit);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_flush_ready: got %b expected 1", in_ready);
        end
        out_ready = 1'b1;
        drive(b);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (out_valid !== (c == 3)) begin
                errors++;
                $display("FAIL rst_latency[%0d]: got out_valid=%b expected %0d", c, out_valid, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (out_posit !== b.ex) begin
                    errors++;
                    $display("FAIL rst_first_beat: got %h expected %h", out_posit, b.ex);
                end
            end
            if (c < 3) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_scale  = '0;
        in_frac   = '0;
        in_sticky = 1'b0;
        in_zero   = 1'b0;
        in_nar    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_basic();
        test_rne();
        test_saturation();
        test_specials();
        test_backpressure();
        test_reset_inflight();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
